// File: rtl/riscvibe_wb_pipeline_if.sv
// Issue / operand / write-back bundle between the execute stage and the
// write-back pipeline. The execute side is the master; the pipeline is the slave.
interface riscvibe_wb_pipeline_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_we;
  logic                  issue_is_load;
  logic [XLEN-1:0]       issue_data;
  logic                  branch_taken;
  logic [XLEN-1:0]       load_data;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic                  rs1_used;
  logic                  rs2_used;
  logic [XLEN-1:0]       rs1_rf_data;
  logic [XLEN-1:0]       rs2_rf_data;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic                  stall;
  logic                  squash;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;

  modport master (
    output issue_valid, issue_rd, issue_we, issue_is_load, issue_data,
           branch_taken, load_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
           rs1_rf_data, rs2_rf_data,
    input  rs1_data, rs2_data, stall, squash, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_is_load, issue_data,
           branch_taken, load_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
           rs1_rf_data, rs2_rf_data,
    output rs1_data, rs2_data, stall, squash, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/riscvibe_wb_pipeline.sv
// Write-back / forwarding / hazard block for RISC-Vibe.
// Keeps WB_DEPTH stages of in-flight register writes, forwards youngest-first
// to both operand ports, stalls on not-yet-returned load data and squashes
// FLUSH_SLOTS issues after a taken branch via a 2-bit down-counter.
module riscvibe_wb_pipeline #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int WB_DEPTH     = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_SLOTS  = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  riscvibe_wb_pipeline_if.slave bus
);

  logic [WB_DEPTH-1:0]   st_valid;
  logic [WB_DEPTH-1:0]   st_pend;
  logic [REG_ADDR_W-1:0] st_rd   [WB_DEPTH];
  logic [XLEN-1:0]       st_data [WB_DEPTH];

  logic [1:0]            squash_cnt;
  logic                  squash;
  logic                  stall;
  logic                  accept;

  logic [XLEN-1:0]       rs1_fwd;
  logic [XLEN-1:0]       rs2_fwd;
  logic                  rs1_pend;
  logic                  rs2_pend;

  logic                  s0_valid;
  logic                  s0_pend;
  logic [REG_ADDR_W-1:0] s0_rd;
  logic [XLEN-1:0]       s0_data;

  assign squash = (squash_cnt != 2'd0);

  // Operand forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    rs1_fwd  = bus.rs1_rf_data;
    rs2_fwd  = bus.rs2_rf_data;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = WB_DEPTH - 1; i >= 0; i--) begin
      if (st_valid[i] && (st_rd[i] == bus.rs1_addr) && (bus.rs1_addr != '0)) begin
        rs1_fwd  = st_data[i];
        rs1_pend = st_pend[i];
      end
      if (st_valid[i] && (st_rd[i] == bus.rs2_addr) && (bus.rs2_addr != '0)) begin
        rs2_fwd  = st_data[i];
        rs2_pend = st_pend[i];
      end
    end
  end

  // Hazard detection and the stage-0 entry built from the issuing instruction.
  always_comb begin
    stall    = bus.issue_valid && !squash &&
               ((bus.rs1_used && rs1_pend) || (bus.rs2_used && rs2_pend));
    accept   = bus.issue_valid && !squash && !stall;
    s0_valid = accept && bus.issue_we && (bus.issue_rd != '0);
    s0_pend  = 1'b0;
    s0_rd    = '0;
    s0_data  = '0;
    if (s0_valid) begin
      s0_pend = bus.issue_is_load && (LOAD_LATENCY > 0);
      s0_rd   = bus.issue_rd;
      s0_data = (bus.issue_is_load && (LOAD_LATENCY == 0)) ? bus.load_data
                                                            : bus.issue_data;
    end
  end

  // Shift register of in-flight writes; a pending load picks up its data
  // as it leaves stage LOAD_LATENCY-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_pend  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        st_rd[i]   <= '0;
        st_data[i] <= '0;
      end
    end else begin
      st_valid[0] <= s0_valid;
      st_pend[0]  <= s0_pend;
      st_rd[0]    <= s0_rd;
      st_data[0]  <= s0_data;
      for (int i = 1; i < WB_DEPTH; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_pend[i]  <= st_pend[i-1];
        st_rd[i]    <= st_rd[i-1];
        st_data[i]  <= st_data[i-1];
        if ((LOAD_LATENCY >= 1) && (i == LOAD_LATENCY) &&
            st_valid[i-1] && st_pend[i-1]) begin
          st_data[i] <= bus.load_data;
          st_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Branch shadow counter: reloads on an accepted taken branch, counts down
  // only on cycles that actually present an instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      squash_cnt <= 2'd0;
    end else if (accept && bus.branch_taken) begin
      squash_cnt <= 2'(FLUSH_SLOTS);
    end else if (bus.issue_valid && squash) begin
      squash_cnt <= squash_cnt - 2'd1;
    end
  end

  assign bus.rs1_data = rs1_fwd;
  assign bus.rs2_data = rs2_fwd;
  assign bus.stall    = stall;
  assign bus.squash   = squash;
  assign bus.rf_we    = st_valid[WB_DEPTH-1];
  assign bus.rf_waddr = st_rd[WB_DEPTH-1];
  assign bus.rf_wdata = st_data[WB_DEPTH-1];

endmodule

// File: tb/tb_riscvibe_wb_pipeline.sv
// Directed vector bench for riscvibe_wb_pipeline, built with WB_DEPTH=2,
// LOAD_LATENCY=1, FLUSH_SLOTS=2. Each vector is one clock cycle: inputs are
// driven after the falling edge and all outputs are compared just after.
module tb_riscvibe_wb_pipeline;

  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [31:0] idata;
    logic        br;
    logic [31:0] ldata;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_stall;
    logic        e_sq;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  vec_t vecs[$];

  riscvibe_wb_pipeline_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  riscvibe_wb_pipeline #(
    .XLEN(32), .REG_ADDR_W(5), .WB_DEPTH(2), .LOAD_LATENCY(1), .FLUSH_SLOTS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rd, input logic we, input logic ld,
    input logic [31:0] idata, input logic br, input logic [31:0] ldata,
    input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [31:0] e_rs1, input logic [31:0] e_rs2, input logic e_stall,
    input logic e_sq, input logic e_we, input logic [4:0] e_wa,
    input logic [31:0] e_wd);
    vec_t v;
    v.rst_n = 1'b1; v.iv = iv; v.rd = rd; v.we = we; v.ld = ld;
    v.idata = idata; v.br = br; v.ldata = ldata;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_stall = e_stall; v.e_sq = e_sq;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n            = v.rst_n;
    bus.issue_valid  = v.iv;
    bus.issue_rd     = v.rd;
    bus.issue_we     = v.we;
    bus.issue_is_load = v.ld;
    bus.issue_data   = v.idata;
    bus.branch_taken = v.br;
    bus.load_data    = v.ldata;
    bus.rs1_addr     = v.rs1;
    bus.rs1_used     = v.u1;
    bus.rs2_addr     = v.rs2;
    bus.rs2_used     = v.u2;
    bus.rs1_rf_data  = R1;
    bus.rs2_rf_data  = R2;
    #1;
    vectors++;
    chk("rs1_data", idx, bus.rs1_data, v.e_rs1);
    chk("rs2_data", idx, bus.rs2_data, v.e_rs2);
    chk("stall",    idx, {31'd0, bus.stall},  {31'd0, v.e_stall});
    chk("squash",   idx, {31'd0, bus.squash}, {31'd0, v.e_sq});
    chk("rf_we",    idx, {31'd0, bus.rf_we},  {31'd0, v.e_we});
    chk("rf_waddr", idx, {27'd0, bus.rf_waddr}, {27'd0, v.e_wa});
    chk("rf_wdata", idx, bus.rf_wdata, v.e_wd);
  endtask

  initial begin
    vec_t rv;
    vectors     = 0;
    miscompares = 0;

    //          iv rd  we ld idata        br ldata        rs1 u1 rs2 u2 | e_rs1        e_rs2        st sq we wa  wd
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    // forwarding and write-back timing
    vecs.push_back(mk(1, 5, 1, 0, 32'h1234,   0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      5, 1, 0, 0, 32'h1234,    R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 3, 1, 0, 32'hA,      0, 32'h0,      5, 1, 0, 0, 32'h1234,    R2,          0, 0, 1, 5,  32'h1234));
    vecs.push_back(mk(1, 3, 1, 0, 32'hB,      0, 32'h0,      0, 0, 3, 1, R1,          32'hA,       0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 3, 1, R1,          32'hB,       0, 0, 1, 3,  32'hA));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 3, 1, R1,          32'hB,       0, 0, 1, 3,  32'hB));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 3, 1, R1,          R2,          0, 0, 0, 0,  32'h0));
    // load-use stall and load data capture
    vecs.push_back(mk(1, 7, 1, 1, 32'h5555,   0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 8, 1, 0, 32'h88,     0, 32'hDEAD,   7, 1, 0, 0, 32'h5555,    R2,          1, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 8, 1, 0, 32'h88,     0, 32'h0,      7, 1, 0, 0, 32'hDEAD,    R2,          0, 0, 1, 7,  32'hDEAD));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      8, 1, 0, 0, 32'h88,      R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 7, 1, 1, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 1, 8,  32'h88));
    vecs.push_back(mk(1, 10, 1, 0, 32'h10,    0, 32'hBEEF,   7, 0, 7, 0, 32'h0,       32'h0,       0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      7, 1, 0, 0, 32'hBEEF,    R2,          0, 0, 1, 7,  32'hBEEF));
    // younger pending match hides an older ready one
    vecs.push_back(mk(1, 12, 1, 0, 32'hC0,    0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 1, 10, 32'h10));
    vecs.push_back(mk(1, 12, 1, 1, 32'h0,     0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 13, 1, 0, 32'h13,    0, 32'h7777,   0, 0, 12, 1, R1,         32'h0,       1, 0, 1, 12, 32'hC0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 12, 1, R1,         32'h7777,    0, 0, 1, 12, 32'h7777));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    // branch shadow: idle cycles hold the count, branch ignored while squashing
    vecs.push_back(mk(1, 1, 1, 0, 32'h1,      1, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 9, 1, 0, 32'h99,     0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 1, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 1, 1, 1,  32'h1));
    vecs.push_back(mk(1, 9, 1, 0, 32'h9A,     1, 32'h0,      1, 1, 0, 0, R1,          R2,          0, 1, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    // squashed instruction reading a pending load does not stall
    vecs.push_back(mk(1, 14, 1, 1, 32'h0,     1, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(1, 15, 1, 0, 32'hF,     0, 32'h1414,   14, 1, 0, 0, 32'h0,      R2,          0, 1, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      14, 1, 0, 0, 32'h1414,   R2,          0, 1, 1, 14, 32'h1414));
    vecs.push_back(mk(1, 15, 1, 0, 32'hF,     0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 1, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    // x0 is never written or forwarded
    vecs.push_back(mk(1, 0, 1, 0, 32'hFF,     0, 32'h0,      0, 1, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 0, R1,          R2,          0, 0, 0, 0,  32'h0));

    rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_we = 1'b0;
    bus.issue_is_load = 1'b0; bus.issue_data = '0; bus.branch_taken = 1'b0;
    bus.load_data = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.rs1_used = 1'b0; bus.rs2_used = 1'b0;
    bus.rs1_rf_data = R1; bus.rs2_rf_data = R2;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset with two writes in flight, a third issuing and the branch shadow active.
    apply(mk(1, 20, 1, 0, 32'h20, 0, 32'h0, 0, 0, 0, 0, R1, R2, 0, 0, 0, 0, 32'h0), 100);
    apply(mk(1, 21, 1, 0, 32'h21, 1, 32'h0, 0, 0, 0, 0, R1, R2, 0, 0, 0, 0, 32'h0), 101);
    rv = mk(1, 22, 1, 0, 32'h22, 0, 32'h0, 21, 1, 20, 1, 32'h21, 32'h20, 0, 1, 1, 20, 32'h20);
    rv.rst_n = 1'b0;
    apply(rv, 102);
    apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 21, 1, 20, 1, R1, R2, 0, 0, 0, 0, 32'h0), 103);
    apply(mk(1, 23, 1, 0, 32'h23, 0, 32'h0, 0, 0, 0, 0, R1, R2, 0, 0, 0, 0, 32'h0), 104);
    apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, R1, R2, 0, 0, 0, 0, 32'h0), 105);
    apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, R1, R2, 0, 0, 1, 23, 32'h23), 106);
    apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, R1, R2, 0, 0, 0, 0, 32'h0), 107);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscvibe_wb_pipeline.md
Name: riscvibe_wb_pipeline

Overview:
- Parametrised write-back / forwarding / hazard block for deeper RISC-Vibe pipelines.
- Replaces the fixed single-stage write-back register, single-stage forwarding and 1-slot flush in the core top level.
- Holds WB_DEPTH stages of in-flight register writes and forwards youngest-first to two read ports.
- Detects load-use hazards on not-yet-returned load data (stall) and squashes FLUSH_SLOTS issued instructions after a taken branch.

Parameters:
- XLEN, 32: register data width.
- REG_ADDR_W, 5: register address width.
- WB_DEPTH, 2: in-flight write-back stages, legal 1..4; the register-file write occurs WB_DEPTH cycles after issue.
- LOAD_LATENCY, 1: cycles after issue before load data is valid, legal 0..WB_DEPTH-1.
- FLUSH_SLOTS, 1: valid issues squashed after a taken branch, legal 0..3.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- issue_valid, in, 1: instruction present at issue (execute) this cycle.
- issue_rd, in, REG_ADDR_W: destination register.
- issue_we, in, 1: instruction writes rd.
- issue_is_load, in, 1: rd value comes from load_data.
- issue_data, in, XLEN: result for non-load instructions.
- branch_taken, in, 1: the issuing instruction redirects the PC.
- load_data, in, XLEN: load return data (timing defined below).
- rs1_addr, rs2_addr, in, REG_ADDR_W: source registers of the issuing instruction.
- rs1_used, rs2_used, in, 1: source is actually read.
- rs1_rf_data, rs2_rf_data, in, XLEN: raw register-file read data.
- rs1_data, rs2_data, out, XLEN: forwarded operands (combinational).
- stall, out, 1: front end must hold the issuing instruction (combinational).
- squash, out, 1: issuing instruction is flushed; suppress memory writes/reads.
- rf_we, out, 1: register-file write enable (registered).
- rf_waddr, out, REG_ADDR_W: register-file write address (registered).
- rf_wdata, out, XLEN: register-file write data (registered).

Behaviour:
- Entry fields: valid, rd, data, pending. Stage 0 is loaded at the clock edge ending the issue cycle. All stages shift by one every cycle; the back end never stalls.
- rf_we/rf_waddr/rf_wdata = stage WB_DEPTH-1 contents. An entry issued in cycle t is presented on rf_* in cycle t+WB_DEPTH.
- accept = issue_valid && !squash && !stall.
- Stage 0 valid <= accept && issue_we && (issue_rd != 0). Otherwise a bubble is inserted (valid=0).
- pending <= issue_is_load && LOAD_LATENCY>0.
- data <= issue_data, or load_data when issue_is_load and LOAD_LATENCY==0.
- LOAD_LATENCY>=1: when a valid pending entry occupies stage LOAD_LATENCY-1, load_data is captured into it on the shift and pending clears. Invalid entries ignore load_data.
- Forwarding, per port:
  - Scan stages 0..WB_DEPTH-1, youngest (stage 0) first. Match = valid && rd == rsX_addr && rsX_addr != 0.
  - First match supplies data; no match supplies rsX_rf_data; x0 always returns rsX_rf_data.
  - The last stage is included in the scan, so the same-cycle RF write is covered.
- Stall:
  - stall = issue_valid && !squash && ((rs1_used && first rs1 match pending) || (rs2_used && first rs2 match pending)).
  - An older non-pending match behind a younger pending match still stalls.
- Squash counter (2 bits):
  - Reset 0. squash = (cnt != 0).
  - On accept && branch_taken: cnt <= FLUSH_SLOTS.
  - Else if issue_valid && cnt != 0: cnt <= cnt-1.
  - Cycles with issue_valid=0 do not decrement.
  - branch_taken is ignored while squash or stall is asserted.
  - Squashed instructions create no entry and never stall.
- Reset (rst_n low at a clock edge):
  - All entries invalid, pending 0, cnt 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, squash=0.
  - In-flight writes are discarded, including those reset mid-operation.
  - stall/rs*_data remain combinational from the reset state: stall=0, rs*_data=rs*_rf_data.

Test Plan:
- WB_DEPTH=2: issue rd=5, data=0x1234 at t; at t+1 read rs1=5 with rs1_rf_data=0 -> rs1_data=0x1234. At t+2 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234; at t+3 rf_we=0.
- Youngest wins: x3=0xA at t, x3=0xB at t+1; read rs2=3 at t+2 -> rs2_data=0xB. Then rf writes 0xA at t+2 and 0xB at t+3.
- LOAD_LATENCY=1: load rd=7 at t; at t+1 issue with rs1=7, rs1_used=1 and load_data=0xDEAD -> stall=1, no entry. At t+2 re-present -> stall=0, rs1_data=0xDEAD. With rs1_used=0 at t+1 -> stall=0.
- FLUSH_SLOTS=2: branch_taken with rd=1 at t (entry kept) -> squash=1 at t+1. Idle at t+2 keeps squash=1; squash=1 on the t+3 issue, then 0 at t+4. Squashed writes to x9 never appear on rf_*.
- Issue rd=0, issue_data=0xFF -> rf_we never asserts. Read rs1=0 -> rs1_data=rs1_rf_data.
- Three entries in flight; rst_n=0 for one edge -> rf_we=0, squash=0, stall=0 next cycle. No rf write follows.
